// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Size encodings and FSM state type.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with extension,
// and sub-word merge for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [7:0]  b_val;
    logic [15:0] h_val;
    logic [31:0] b_mask;
    logic [31:0] h_mask;

    assign sh_b   = {addr_lo, 3'b000};
    assign sh_h   = {addr_lo[1], 4'b0000};
    assign b_val  = 8'(rd_word >> sh_b);
    assign h_val  = 16'(rd_word >> sh_h);
    assign b_mask = 32'h0000_00ff << sh_b;
    assign h_mask = 32'h0000_ffff << sh_h;

    // Select lane by size; size 11 behaves as word
    always_comb begin
        load_data  = rd_word;
        merge_data = wdata;
        unique case (1'b1)
            size[1]: begin
                load_data  = rd_word;
                merge_data = wdata;
            end
            size == SZ_HALF: begin
                load_data  = {{16{~is_unsigned & h_val[15]}}, h_val};
                merge_data = (rd_word & ~h_mask)
                           | ({16'h0, wdata[15:0]} << sh_h);
            end
            size == SZ_BYTE: begin
                load_data  = {{24{~is_unsigned & b_val[7]}}, b_val};
                merge_data = (rd_word & ~b_mask)
                           | ({24'h0, wdata[7:0]} << sh_b);
            end
            default: begin
                load_data  = rd_word;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time,
// sub-word stores done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    lsu_state_t  state;
    logic        cap_write;
    logic        cap_unsigned;
    logic [1:0]  cap_size;
    logic [1:0]  cap_lane;
    logic [31:0] cap_wdata;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        req_err;
    logic        req_word;

    assign req_word  = req_size[1];
    assign req_ready = (state == IDLE) && !rst;

    // Flag misaligned or out-of-range requests
    always_comb begin
        req_err = 1'b0;
        if (req_size == SZ_HALF && req_addr[0])
            req_err = 1'b1;
        if (req_word && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= MEM_LIMIT)
            req_err = 1'b1;
    end

    lsu_lane_align u_align (
        .rd_word     (mem_read_data),
        .addr_lo     (cap_lane),
        .size        (cap_size),
        .is_unsigned (cap_unsigned),
        .wdata       (cap_wdata),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Request sequencing with registered memory/response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cap_write      <= 1'b0;
            cap_unsigned   <= 1'b0;
            cap_size       <= 2'b00;
            cap_lane       <= 2'b00;
            cap_wdata      <= 32'h0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_error     <= 1'b0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_write    <= req_write;
                        cap_unsigned <= req_unsigned;
                        cap_size     <= req_size;
                        cap_lane     <= req_addr[1:0];
                        cap_wdata    <= req_wdata;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else if (!req_write || !req_word) begin
                            state       <= RD;
                            mem_read    <= 1'b1;
                            mem_address <= {2'b00, req_addr[31:2]};
                        end else begin
                            state          <= WR;
                            mem_write      <= 1'b1;
                            mem_address    <= {2'b00, req_addr[31:2]};
                            mem_write_data <= req_wdata;
                        end
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    if (cap_write) begin
                        state          <= WR;
                        mem_write      <= 1'b1;
                        mem_write_data <= merge_data;
                    end else begin
                        state       <= RESP;
                        mem_address <= 32'h0;
                        resp_valid  <= 1'b1;
                        resp_rdata  <= load_data;
                    end
                end
                WR: begin
                    state          <= RESP;
                    mem_write      <= 1'b0;
                    mem_address    <= 32'h0;
                    mem_write_data <= 32'h0;
                    resp_valid     <= 1'b1;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit
// against an arithmetic memory model.
module tb_load_store_unit;

    localparam int MW = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [MW];
    logic [31:0] ref_mem [MW];
    logic        pre_en = 1'b0;
    int          pre_idx = 0;
    logic [31:0] pre_val = 32'h0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_raddr = 32'h0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    // data_memory: combinational read, write on clock edge
    assign mem_read_data = (mem_read && mem_address < MW)
                         ? mem[mem_address[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_val;
        if (mem_read) begin
            rd_cnt     <= rd_cnt + 1;
            last_raddr <= mem_address;
        end
        if (mem_write) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_address;
            last_wdata <= mem_write_data;
            if (mem_address < MW)
                mem[mem_address[7:0]] <= mem_write_data;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Reference: expected result of one request from the rules
    task automatic model(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int nrd,
                         output int nwr, output logic [31:0] new_word);
        longint word, scale, width, field, nf;
        int idx, nbytes;
        idx    = int'(a / 4);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err    = (a / 4 >= MW) || (a % nbytes != 0);
        rdata  = 32'h0;
        new_word = 32'h0;
        nrd = 0; nwr = 0; lat = 1;
        if (err) return;
        word  = longint'(ref_mem[idx]);
        scale = longint'(1) << (8 * (a % 4));
        if (nbytes == 4) scale = 1;
        width = longint'(1) << (8 * nbytes);
        field = (word / scale) % width;
        if (!w) begin
            if (!u && field >= width / 2)
                field = field - width;
            rdata = 32'(field);
            lat = 2; nrd = 1;
        end else begin
            nf = longint'(wd) % width;
            new_word = 32'(word - field * scale + nf * scale);
            ref_mem[idx] = new_word;
            nwr = 1;
            nrd = (nbytes == 4) ? 0 : 1;
            lat = (nbytes == 4) ? 2 : 3;
        end
    endtask

    task automatic do_req(input string tag, input logic w,
                          input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] e_rd, e_new;
        logic e_err;
        int e_lat, e_nrd, e_nwr, lat, guard;
        model(w, sz, u, a, wd, e_rd, e_err, e_lat, e_nrd, e_nwr, e_new);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = u; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        rd_cnt = 0; wr_cnt = 0;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!resp_valid && lat < 8);
        check({tag, ".lat"}, 32'(lat), 32'(e_lat));
        check({tag, ".rdata"}, resp_rdata, e_rd);
        check({tag, ".err"}, 32'(resp_error), 32'(e_err));
        check({tag, ".nrd"}, 32'(rd_cnt), 32'(e_nrd));
        check({tag, ".nwr"}, 32'(wr_cnt), 32'(e_nwr));
        if (e_nrd > 0)
            check({tag, ".raddr"}, last_raddr, a / 4);
        if (e_nwr > 0) begin
            check({tag, ".waddr"}, last_waddr, a / 4);
            check({tag, ".wdata"}, last_wdata, e_new);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          guard;
        for (int i = 0; i < MW; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'h0);
        check("rst.resp_valid", 32'(resp_valid), 32'h0);
        check("rst.mem_ctl", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst.mem_addr", mem_address, 32'h0);
        check("rst.rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        #1;
        check("idle.ready", 32'(req_ready), 32'h1);

        preload(2, 32'h1122_3344);
        preload(3, 32'h0000_80ff);
        do_req("ld_word", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check("ld_word.value", resp_rdata, 32'h1122_3344);
        do_req("ld_sb", 1'b0, 2'b00, 1'b0, 32'hc, 32'h0);
        check("ld_sb.value", resp_rdata, 32'hffff_ffff);
        do_req("ld_uh", 1'b0, 2'b01, 1'b1, 32'hc, 32'h0);
        check("ld_uh.value", resp_rdata, 32'h0000_80ff);
        do_req("ld_sh", 1'b0, 2'b01, 1'b0, 32'hc, 32'h0);
        check("ld_sh.value", resp_rdata, 32'hffff_80ff);
        do_req("ld_ub", 1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
        check("ld_ub.value", resp_rdata, 32'h0000_0033);
        do_req("st_byte", 1'b1, 2'b00, 1'b0, 32'ha, 32'hab);
        check("st_byte.mem", mem[2], 32'h11ab_3344);
        do_req("st_word", 1'b1, 2'b10, 1'b0, 32'h8, 32'd123);
        check("st_word.mem", mem[2], 32'd123);
        do_req("err_mis", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        do_req("err_range", 1'b0, 2'b00, 1'b0, 32'h400, 32'h0);
        do_req("sz11_ld", 1'b0, 2'b11, 1'b0, 32'hc, 32'h0);

        // reset during the write cycle of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_addr = 32'h10; req_wdata = 32'h5a;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!mem_write && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        check("abort.saw_write", 32'(mem_write), 32'h1);
        wr_cnt = 0;
        rst = 1'b1;
        #1;
        check("abort.write_drop", 32'(mem_write), 32'h0);
        check("abort.resp", 32'(resp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort.ready", 32'(req_ready), 32'h1);
        repeat (3) begin
            @(negedge clk);
            check("abort.no_resp", 32'(resp_valid), 32'h0);
        end
        check("abort.no_wr", 32'(wr_cnt), 32'h0);
        check("abort.mem", mem[4], 32'h0);

        // back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        req_addr = 32'h8;
        @(negedge clk);
        req_addr = 32'hc;
        check("b2b.rd_busy", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("b2b.resp1", 32'(resp_valid), 32'h1);
        check("b2b.resp1_data", resp_rdata, ref_mem[2]);
        check("b2b.resp1_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("b2b.idle_ready", 32'(req_ready), 32'h1);
        check("b2b.idle_resp", 32'(resp_valid), 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b.second_rd", 32'(mem_read), 32'h1);
        check("b2b.second_addr", mem_address, 32'h3);
        @(negedge clk);
        check("b2b.resp2_data", resp_rdata, ref_mem[3]);

        // random traffic
        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0)
               ? 32'($urandom_range(MW * 4, MW * 4 + 64))
               : 32'($urandom_range(0, 31));
            do_req("rand", 1'($urandom), sz, 1'($urandom), a, $urandom);
        end
        for (int i = 0; i < 8; i++)
            check("final.mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
